// File: rtl/regfile_alu_pkg.sv
// regfile_alu_pkg: opcodes, FSM states and flag bundle shared by regfile_alu_mc
package regfile_alu_pkg;
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_MUL = 4'd8
    } op_e;
    typedef enum logic {IDLE, BUSY} state_e;
    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;
endpackage

// File: rtl/iter_mul.sv
// iter_mul: DATA_W-cycle unsigned shift-add multiplier
// Ports: clk, rst_n (async active-low); start loads a/b; busy while iterating;
//        done marks the final iteration, when product already holds the full result.
module iter_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    import regfile_alu_pkg::*;
    localparam int CW = $clog2(DATA_W);
    logic [2*DATA_W-1:0] mcand, acc;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;
    // product is the accumulator after this cycle's add, so the last step can be written back directly
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && cnt == CW'(DATA_W - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= !done;
        end
    end
endmodule

// File: rtl/regfile_alu_mc.sv
// regfile_alu_mc: register file + ALU executing one op per valid/ready handshake, iterative MUL
// Ports: clk, rst_n (async active-low); op_valid/op_ready handshake; op_code, ra1, ra2, wa, we,
//        alu_src, imm describe the op; done pulses with result and zero/neg/carry/ovf flags,
//        illegal flags an unsupported op_code; cpu_out mirrors rf[OUT_REG].
module regfile_alu_mc
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int OUT_REG  = NUM_REGS - 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     wa,
    input  logic              we,
    input  logic              alu_src,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              carry,
    output logic              ovf,
    output logic              illegal,
    output logic [DATA_W-1:0] cpu_out
);
    localparam int SW = $clog2(DATA_W);
    logic [DATA_W-1:0]   rf [NUM_REGS];
    logic [DATA_W-1:0]   src_a, src_b, alu_res, nres, wr_data, result_q;
    logic [DATA_W:0]     sum, diff;
    logic [2*DATA_W-1:0] product;
    logic [AW-1:0]       wr_addr, mul_wa;
    logic                alu_c, alu_v, alu_ill, nc, nv, nill, wr_en, upd, accept, mul_start;
    logic                mul_we, mul_busy, mul_done, carry_q, ovf_q, done_q, ill_q;
    state_e              state_q, state_d;
    op_e                 op;
    flags_t              flags;
    assign op      = op_e'(op_code);
    assign src_a   = rf[ra1];
    assign src_b   = alu_src ? imm : rf[ra2];
    assign sum     = {1'b0, src_a} + {1'b0, src_b};
    assign diff    = {1'b0, src_a} - {1'b0, src_b};
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_AND: alu_res = src_a & src_b;
            OP_OR:  alu_res = src_a | src_b;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_SLT: alu_res = DATA_W'($signed(src_a) < $signed(src_b));
            OP_SLL: alu_res = src_a << src_b[SW-1:0];
            OP_SRL: alu_res = src_a >> src_b[SW-1:0];
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end
    iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
    // Write-back and flag update happen at the accept edge (single-cycle ops)
    // or at the multiplier's final iteration edge.
    always_comb begin
        state_d   = state_q;
        accept    = op_valid && state_q == IDLE;
        mul_start = accept && op == OP_MUL;
        upd       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = wa;
        wr_data   = alu_res;
        nres      = alu_res;
        nc        = alu_c;
        nv        = alu_v;
        nill      = alu_ill;
        if (state_q == IDLE) begin
            if (mul_start) state_d = BUSY;
            else if (accept) begin
                upd   = 1'b1;
                wr_en = we && !alu_ill;
            end
        end else if (mul_busy && mul_done) begin
            state_d = IDLE;
            upd     = 1'b1;
            wr_en   = mul_we;
            wr_addr = mul_wa;
            wr_data = product[DATA_W-1:0];
            nres    = product[DATA_W-1:0];
            nc      = |product[2*DATA_W-1:DATA_W];
            nv      = 1'b0;
            nill    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
            mul_wa   <= '0;
            mul_we   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= upd;
            ill_q   <= upd && nill;
            if (upd) begin
                result_q <= nres;
                carry_q  <= nc;
                ovf_q    <= nv;
            end
            if (mul_start) begin
                mul_wa <= wa;
                mul_we <= we;
            end
            // rf[0] is never written, so it reads as zero forever
            if (wr_en && wr_addr != '0) rf[wr_addr] <= wr_data;
        end
    end
    assign flags    = '{zero: result_q == '0, neg: result_q[DATA_W-1], carry: carry_q, ovf: ovf_q};
    assign op_ready = state_q == IDLE;
    assign done     = done_q;
    assign illegal  = ill_q;
    assign result   = result_q;
    assign zero     = flags.zero;
    assign neg      = flags.neg;
    assign carry    = flags.carry;
    assign ovf      = flags.ovf;
    assign cpu_out  = rf[OUT_REG];
endmodule

// File: tb/tb_regfile_alu_mc.sv
// tb_regfile_alu_mc: directed stimulus, integer-arithmetic reference model checked every cycle
module tb_regfile_alu_mc;
    logic       clk = 0, rst_n = 0, op_valid = 0, we = 0, alu_src = 0;
    logic [3:0] op_code = 0, ra1 = 0, ra2 = 0, wa = 0;
    logic [7:0] imm = 0;
    logic       op_ready, done, zero, neg, carry, ovf, illegal;
    logic [7:0] result, cpu_out;
    int checks = 0, passed = 0;
    int mrf [16];
    bit m_busy, m_done, m_ill, m_c, m_v, m_we;
    int m_res, m_left, m_wa, m_prod;

    always #5 clk = ~clk;

    regfile_alu_mc dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .ra1(ra1), .ra2(ra2), .wa(wa), .we(we), .alu_src(alu_src), .imm(imm), .done(done),
        .result(result), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .illegal(illegal),
        .cpu_out(cpu_out)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sx(int v);
        return v >= 128 ? v - 256 : v;
    endfunction

    task automatic model_reset();
        foreach (mrf[i]) mrf[i] = 0;
        m_busy = 0; m_done = 0; m_ill = 0; m_c = 0; m_v = 0; m_res = 0; m_left = 0;
    endtask

    // Advance the model over the clock edge just passed; inputs are still those sampled at it.
    task automatic model_step();
        int a, b, r;
        bit c, v, il;
        m_done = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_ill = 0; m_v = 0;
                m_res = m_prod % 256; m_c = m_prod > 255;
                if (m_we && m_wa != 0) mrf[m_wa] = m_res;
            end
        end else if (op_valid) begin
            a = mrf[ra1]; b = alu_src ? int'(imm) : mrf[ra2];
            r = 0; c = 0; v = 0; il = 0;
            case (op_code)
                0: r = a & b;
                1: r = a | b;
                4: r = a ^ b;
                2: begin r = (a + b) % 256; c = a + b > 255; v = (sx(a) + sx(b) > 127) || (sx(a) + sx(b) < -128); end
                3: begin r = (a - b + 256) % 256; c = a < b; v = (sx(a) - sx(b) > 127) || (sx(a) - sx(b) < -128); end
                5: r = int'(sx(a) < sx(b));
                6: r = (a << (b % 8)) % 256;
                7: r = a >> (b % 8);
                8: begin m_busy = 1; m_left = 8; m_prod = a * b; m_wa = wa; m_we = we; end
                default: il = 1;
            endcase
            if (op_code != 8) begin
                m_done = 1; m_ill = il; m_res = r; m_c = c; m_v = v;
                if (we && wa != 0 && !il) mrf[wa] = r;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        chk("op_ready", op_ready, !m_busy);
        chk("done", done, m_done);
        chk("illegal", illegal, m_done && m_ill);
        chk("result", result, m_res);
        chk("zero", zero, m_res == 0);
        chk("neg", neg, m_res >= 128);
        chk("carry", carry, m_c);
        chk("ovf", ovf, m_v);
        chk("cpu_out", cpu_out, mrf[15]);
    end

    // Called at negedge+1; returns at negedge+1 right after the accept edge.
    task automatic op(input int code, input int d, input int s1, input int s2, input bit w, input bit src, input int im);
        int n = 0;
        op_code = 4'(code); wa = 4'(d); ra1 = 4'(s1); ra2 = 4'(s2); we = w; alu_src = src; imm = 8'(im);
        op_valid = 1;
        while (!op_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!op_ready) chk("op_timeout", 0, 1);
        @(negedge clk); #1;
        op_valid = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        int k, lows, dones;
        wait_cycles(3);
        chk("rst_cpu_out", cpu_out, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ready", op_ready, 1);
        chk("rst_done", done, 0);
        rst_n = 1;
        wait_cycles(1);
        for (int i = 1; i < 16; i++) begin
            op(1, 0, i, 0, 0, 1, 0);
            chk("rst_rf_read", result, 0);
        end
        op(2, 3, 0, 0, 1, 1, 5);
        chk("add_r3", result, 5);
        op(2, 15, 3, 0, 1, 1, 250);
        chk("add_ff", result, 8'hFF);
        chk("add_carry", carry, 0);
        chk("add_neg", neg, 1);
        chk("add_cpu_out", cpu_out, 8'hFF);
        op(2, 1, 0, 0, 1, 1, 8'h80);
        op(3, 2, 1, 0, 1, 1, 1);
        chk("sub_res", result, 8'h7F);
        chk("sub_ovf", ovf, 1);
        chk("sub_carry", carry, 0);
        op(3, 2, 0, 1, 1, 0, 0);
        chk("sub_borrow_res", result, 8'h80);
        chk("sub_borrow", carry, 1);
        op(2, 1, 0, 0, 1, 1, 13);
        op(2, 2, 0, 0, 1, 1, 11);
        op(8, 4, 1, 2, 1, 0, 0);
        k = 0; lows = 0;
        while (!done && k < 20) begin
            if (!op_ready) lows++;
            wait_cycles(1); k++;
        end
        chk("mul_latency", k, 8);
        chk("mul_ready_low", lows, 8);
        chk("mul_res", result, 8'h8F);
        chk("mul_carry", carry, 0);
        op(1, 15, 4, 0, 1, 1, 0);
        chk("mul_r4", cpu_out, 8'h8F);
        op(2, 1, 0, 0, 1, 1, 20);
        op(2, 2, 0, 0, 1, 1, 20);
        op(8, 4, 1, 2, 1, 0, 0);
        k = 0;
        while (!done && k < 20) begin wait_cycles(1); k++; end
        chk("mul_hi_res", result, 8'h90);
        chk("mul_hi_carry", carry, 1);
        op(8, 4, 1, 2, 1, 0, 0);
        op(2, 15, 4, 0, 1, 1, 1);
        chk("mul_held_op", cpu_out, 8'h91);
        op(2, 0, 0, 0, 1, 1, 7);
        chk("r0_add_res", result, 7);
        op(1, 6, 0, 0, 1, 1, 0);
        chk("r0_stays_zero", result, 0);
        op(15, 15, 1, 2, 1, 0, 0);
        chk("ill_done", done, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_result", result, 0);
        chk("ill_no_write", cpu_out, 8'h91);
        op(6, 7, 1, 0, 1, 1, 3);
        chk("sll", result, 8'hA0);
        op(7, 7, 1, 0, 1, 1, 2);
        chk("srl", result, 5);
        op(5, 7, 0, 0, 1, 1, 8'hFF);
        chk("slt_neg", result, 0);
        op(5, 7, 0, 0, 1, 1, 1);
        chk("slt_pos", result, 1);
        op(4, 7, 1, 0, 1, 1, 8'h0F);
        op(0, 7, 1, 2, 1, 0, 0);
        op(2, 7, 3, 0, 1, 1, 8'hFE);
        op(3, 7, 7, 1, 1, 0, 0);
        op(7, 7, 4, 1, 1, 0, 0);
        op(8, 15, 1, 2, 1, 0, 0);
        wait_cycles(3);
        rst_n = 0;
        wait_cycles(3);
        rst_n = 1;
        chk("abort_ready", op_ready, 1);
        chk("abort_cpu_out", cpu_out, 0);
        dones = 0;
        repeat (12) begin
            wait_cycles(1);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_no_write", cpu_out, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
